add_final_project: RTL and testbench
====================================

# add_final_project

Top-level controller for the ROM Morse game. A user logs in with a 4-digit ID and then a 6-digit password, both entered one hex digit at a time. Once logged in, the user plays rounds: a digit's Morse pattern, read from an internal ROM, appears on five seven-segment displays, and the user keys in the decoded digit. The block drives all board LEDs and displays and is the FPGA top level.

## Interface
- `ID_CODE`, 16'h5973 — stored user ID, 4 nibbles, first-entered digit in the MSN.
- `PWD_CODE`, 24'hA04A54 — stored password, 6 nibbles, first-entered digit in the MSN.
- `SHOW_CYCLES`, 16 — base number of cycles the Morse pattern stays visible.
- `clk` in 1 — single system clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `UserDigit` in 4 — hex digit being entered (ID, password, or game answer).
- `UserLoad` in 1 — digit-load / round-start button, active-high, edge-detected.
- `LoggedInLED` out 1 — high while logged in.
- `difficulty` in 2 — game visibility level, sampled at round start.
- `load` in 1 — answer-submit button, active-high, edge-detected.
- `correct` out 1 — result of the last answer.
- `logout` in 1 — level, active-high; returns the block to ID entry.
- `display0`..`display4` out 7 each — seven-segment outputs, active-low, bit order {g,f,e,d,c,b,a}.
- `ones_output` out 7 — seven-segment output, same encoding; shows the last entered digit, or the score in game states.
- `correctID` out 1 — high once the ID has matched, until logout or a password failure.

## Operation
- Button presses
  - A press is the cycle where the input is high and its registered previous value is low.
  - Holding a button gives exactly one press.
- States: ID_ENTRY, PWD_ENTRY, GAME_IDLE, GAME_SHOW, GAME_ANSWER.
- ID_ENTRY
  - Each UserLoad press shifts UserDigit into the ID register and increments the digit count.
  - The 4th press compares the shifted value against ID_CODE.
  - Match: correctID=1, go to PWD_ENTRY.
  - Mismatch: clear the count and stay in ID_ENTRY.
- PWD_ENTRY
  - Same shifting as ID_ENTRY, but 6 digits.
  - Match: LoggedInLED=1, score=0, go to GAME_IDLE.
  - Mismatch: correctID=0, go to ID_ENTRY.
- Login displays
  - display3..display0 show the last 4 entered digits in hex; the newest digit is on display0.
  - display4 is blank.
  - ones_output shows the last entered digit.
- GAME_IDLE
  - All displays are blank except ones_output, which shows score mod 10.
  - A UserLoad press latches difficulty and the question digit q, then goes to GAME_SHOW.
  - q sequence: q starts at 0 after reset or login; after each round, q = (q+7) mod 10.
- GAME_SHOW
  - Shows q's standard 5-symbol Morse code on display4 (first symbol) through display0 (last symbol).
  - Dot = 7'h77 (segment d lit); dash = 7'h3F (segment g lit).
  - Visibility by latched difficulty: 00 unlimited; 01 SHOW_CYCLES; 10 SHOW_CYCLES/2; 11 SHOW_CYCLES/4.
  - When the visibility time expires, go to GAME_ANSWER with the pattern blanked.
- Answer submission
  - A load press in GAME_SHOW or GAME_ANSWER evaluates the answer.
  - correct = (UserDigit == q).
  - If correct, score = (score+1) mod 10.
  - Advance q and go to GAME_IDLE.
  - correct holds until the next round starts, then clears.
- Morse ROM
  - 10-entry combinational ROM, 5 bits per entry.
  - Bit 4 is the first symbol; 1 = dash.
  - Entries: 0=11111, 1=01111, 2=00111, 3=00011, 4=00001, 5=00000, 6=10000, 7=11000, 8=11100, 9=11110.
- logout
  - While high in any state other than ID_ENTRY, the next edge forces ID_ENTRY.
  - It clears correctID, LoggedInLED, correct, score, the digit count and q.
- Priority: logout over load over UserLoad. UserLoad is ignored in GAME_SHOW and GAME_ANSWER; load is ignored outside them.

## Timing
- All outputs are registered. A press sampled at edge N gives updated outputs after edge N.
- correctID and LoggedInLED rise after the edge that captures the final digit.
- Reset values
  - LoggedInLED=0, correctID=0, correct=0.
  - All displays blank (7'h7F), ones_output blank.
  - State ID_ENTRY; count, score and q all 0.
- Reset asserted mid-entry or mid-round returns the block to the reset values immediately.
- The visibility timer loads at round start and counts down one per cycle. It expires after exactly N cycles of display.

## Structure
- Shared package holds:
  - the state enum;
  - the blank, dot and dash segment constants;
  - the hex-to-seven-segment function.
- One sub-module: `morse_rom`, digit to 5-bit pattern.

## Test plan
- Reset, then enter ID 5,9,7,3 with UserLoad pulses → correctID=1 after the 4th press, display3..0 show 5,9,7,3, LoggedInLED=0.
- Then enter password A,0,4,A,5,4 → LoggedInLED=1 after the 6th press, ones_output shows 0.
- Enter ID 5,9,7,2 → correctID stays 0 and a new 4-digit entry is accepted. Enter a wrong password → correctID falls to 0.
- Logged in, difficulty=01, UserLoad press → display4..0 show `-----` (0) for exactly 16 cycles, then blank.
- load with UserDigit=0 → correct=1, ones_output shows 1. Next round shows 7 (`--...`); load with UserDigit=3 → correct=0, score stays 1.
- logout high during GAME_SHOW → next edge gives LoggedInLED=0, correctID=0 and blank displays. Asserting rst mid-password gives the same result.

Source files
------------

// File: rtl/add_final_project_pkg.sv
// rtl/add_final_project_pkg.sv - shared states, segment constants and hex decoder for the Morse game
package add_final_project_pkg;

    typedef enum logic [2:0] {
        ID_ENTRY,
        PWD_ENTRY,
        GAME_IDLE,
        GAME_SHOW,
        GAME_ANSWER
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DOT   = 7'h77;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/add_final_project_morse_rom.sv
// rtl/add_final_project_morse_rom.sv - digit to 5-symbol Morse pattern, bit 4 first, 1 = dash
module morse_rom (
    input  logic [3:0] digit,
    output logic [4:0] pattern
);

    // Combinational lookup; codes outside 0..9 read as all dots
    always_comb begin
        case (digit)
            4'd0:    pattern = 5'b11111;
            4'd1:    pattern = 5'b01111;
            4'd2:    pattern = 5'b00111;
            4'd3:    pattern = 5'b00011;
            4'd4:    pattern = 5'b00001;
            4'd5:    pattern = 5'b00000;
            4'd6:    pattern = 5'b10000;
            4'd7:    pattern = 5'b11000;
            4'd8:    pattern = 5'b11100;
            4'd9:    pattern = 5'b11110;
            default: pattern = 5'b00000;
        endcase
    end

endmodule

// File: rtl/add_final_project.sv
// rtl/add_final_project.sv - login plus Morse-reading game top level
module add_final_project
    import add_final_project_pkg::*;
#(
    parameter logic [15:0] ID_CODE     = 16'h5973,
    parameter logic [23:0] PWD_CODE    = 24'hA04A54,
    parameter int          SHOW_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] UserDigit,
    input  logic       UserLoad,
    output logic       LoggedInLED,
    input  logic [1:0] difficulty,
    input  logic       load,
    output logic       correct,
    input  logic       logout,
    output logic [6:0] display0,
    output logic [6:0] display1,
    output logic [6:0] display2,
    output logic [6:0] display3,
    output logic [6:0] display4,
    output logic [6:0] ones_output,
    output logic       correctID
);

    localparam logic [15:0] LEN_FULL    = 16'(SHOW_CYCLES);
    localparam logic [15:0] LEN_HALF    = 16'(SHOW_CYCLES / 2);
    localparam logic [15:0] LEN_QUARTER = 16'(SHOW_CYCLES / 4);

    state_t      state, nxt_state;
    logic [2:0]  cnt, nxt_cnt;
    logic [19:0] entry, nxt_entry;     // recent digits, newest in the low nibble
    logic [3:0]  vld, nxt_vld;         // which of the last 4 display slots hold a digit
    logic [3:0]  score, nxt_score;
    logic [3:0]  q, nxt_q;
    logic [15:0] timer, nxt_timer;     // 0 means the pattern never times out
    logic        nxt_id_ok, nxt_led, nxt_correct;
    logic        ul_prev, ld_prev, ul_press, ld_press;
    logic [23:0] shifted;
    logic [15:0] show_len;
    logic [4:0]  pattern;
    logic [6:0]  nxt_d0, nxt_d1, nxt_d2, nxt_d3, nxt_d4, nxt_ones;

    assign ul_press = UserLoad & ~ul_prev;
    assign ld_press = load & ~ld_prev;
    assign shifted  = {entry, UserDigit};

    morse_rom u_rom (
        .digit   (nxt_q),
        .pattern (pattern)
    );

    // Visibility window chosen by the difficulty sampled at round start
    always_comb begin
        case (difficulty)
            2'b01:   show_len = LEN_FULL;
            2'b10:   show_len = LEN_HALF;
            2'b11:   show_len = LEN_QUARTER;
            default: show_len = 16'd0;
        endcase
    end

    // Next-state logic: logout beats load beats UserLoad
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_entry   = entry;
        nxt_vld     = vld;
        nxt_score   = score;
        nxt_q       = q;
        nxt_timer   = timer;
        nxt_id_ok   = correctID;
        nxt_led     = LoggedInLED;
        nxt_correct = correct;
        if (logout && state != ID_ENTRY) begin
            nxt_state   = ID_ENTRY;
            nxt_cnt     = 3'd0;
            nxt_vld     = 4'd0;
            nxt_score   = 4'd0;
            nxt_q       = 4'd0;
            nxt_timer   = 16'd0;
            nxt_id_ok   = 1'b0;
            nxt_led     = 1'b0;
            nxt_correct = 1'b0;
        end else begin
            case (state)
                ID_ENTRY, PWD_ENTRY: begin
                    if (ul_press) begin
                        nxt_entry = shifted[19:0];
                        nxt_vld   = {vld[2:0], 1'b1};
                        nxt_cnt   = cnt + 3'd1;
                        if (state == ID_ENTRY && cnt == 3'd3) begin
                            nxt_cnt = 3'd0;
                            if (shifted[15:0] == ID_CODE) begin
                                nxt_id_ok = 1'b1;
                                nxt_state = PWD_ENTRY;
                            end
                        end else if (state == PWD_ENTRY && cnt == 3'd5) begin
                            nxt_cnt = 3'd0;
                            if (shifted == PWD_CODE) begin
                                nxt_led   = 1'b1;
                                nxt_score = 4'd0;
                                nxt_q     = 4'd0;
                                nxt_state = GAME_IDLE;
                            end else begin
                                nxt_id_ok = 1'b0;
                                nxt_state = ID_ENTRY;
                            end
                        end
                    end
                end
                GAME_IDLE: begin
                    if (ul_press) begin
                        nxt_state   = GAME_SHOW;
                        nxt_timer   = show_len;
                        nxt_correct = 1'b0;
                    end
                end
                GAME_SHOW, GAME_ANSWER: begin
                    if (ld_press) begin
                        nxt_correct = (UserDigit == q);
                        if (UserDigit == q) begin
                            nxt_score = (score == 4'd9) ? 4'd0 : score + 4'd1;
                        end
                        nxt_q     = (q >= 4'd3) ? q - 4'd3 : q + 4'd7;
                        nxt_state = GAME_IDLE;
                    end else if (state == GAME_SHOW && timer != 16'd0) begin
                        nxt_timer = timer - 16'd1;
                        if (timer == 16'd1) begin
                            nxt_state = GAME_ANSWER;
                        end
                    end
                end
                default: nxt_state = ID_ENTRY;
            endcase
        end
    end

    // Display contents derived from the upcoming state so outputs can be registered
    always_comb begin
        nxt_d0   = SEG_BLANK;
        nxt_d1   = SEG_BLANK;
        nxt_d2   = SEG_BLANK;
        nxt_d3   = SEG_BLANK;
        nxt_d4   = SEG_BLANK;
        nxt_ones = SEG_BLANK;
        case (nxt_state)
            ID_ENTRY, PWD_ENTRY: begin
                if (nxt_vld[0]) nxt_d0 = hex_to_seg(nxt_entry[3:0]);
                if (nxt_vld[1]) nxt_d1 = hex_to_seg(nxt_entry[7:4]);
                if (nxt_vld[2]) nxt_d2 = hex_to_seg(nxt_entry[11:8]);
                if (nxt_vld[3]) nxt_d3 = hex_to_seg(nxt_entry[15:12]);
                nxt_ones = nxt_d0;
            end
            GAME_SHOW: begin
                nxt_d4   = pattern[4] ? SEG_DASH : SEG_DOT;
                nxt_d3   = pattern[3] ? SEG_DASH : SEG_DOT;
                nxt_d2   = pattern[2] ? SEG_DASH : SEG_DOT;
                nxt_d1   = pattern[1] ? SEG_DASH : SEG_DOT;
                nxt_d0   = pattern[0] ? SEG_DASH : SEG_DOT;
                nxt_ones = hex_to_seg(nxt_score);
            end
            default: nxt_ones = hex_to_seg(nxt_score);
        endcase
    end

    // State, button history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ID_ENTRY;
            cnt         <= 3'd0;
            entry       <= 20'd0;
            vld         <= 4'd0;
            score       <= 4'd0;
            q           <= 4'd0;
            timer       <= 16'd0;
            ul_prev     <= 1'b0;
            ld_prev     <= 1'b0;
            correctID   <= 1'b0;
            LoggedInLED <= 1'b0;
            correct     <= 1'b0;
            display0    <= SEG_BLANK;
            display1    <= SEG_BLANK;
            display2    <= SEG_BLANK;
            display3    <= SEG_BLANK;
            display4    <= SEG_BLANK;
            ones_output <= SEG_BLANK;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            entry       <= nxt_entry;
            vld         <= nxt_vld;
            score       <= nxt_score;
            q           <= nxt_q;
            timer       <= nxt_timer;
            ul_prev     <= UserLoad;
            ld_prev     <= load;
            correctID   <= nxt_id_ok;
            LoggedInLED <= nxt_led;
            correct     <= nxt_correct;
            display0    <= nxt_d0;
            display1    <= nxt_d1;
            display2    <= nxt_d2;
            display3    <= nxt_d3;
            display4    <= nxt_d4;
            ones_output <= nxt_ones;
        end
    end

endmodule

// File: tb/tb_add_final_project.sv
// tb/tb_add_final_project.sv - bench for the Morse game top level
module tb_add_final_project;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] UserDigit = 4'd0;
    logic       UserLoad = 1'b0;
    logic [1:0] difficulty = 2'd0;
    logic       load = 1'b0;
    logic       logout = 1'b0;
    logic       LoggedInLED, correct, correctID;
    logic [6:0] display0, display1, display2, display3, display4, ones_output;

    int checks = 0;
    int errors = 0;

    add_final_project dut (
        .clk         (clk),
        .rst         (rst),
        .UserDigit   (UserDigit),
        .UserLoad    (UserLoad),
        .LoggedInLED (LoggedInLED),
        .difficulty  (difficulty),
        .load        (load),
        .correct     (correct),
        .logout      (logout),
        .display0    (display0),
        .display1    (display1),
        .display2    (display2),
        .display3    (display3),
        .display4    (display4),
        .ones_output (ones_output),
        .correctID   (correctID)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: phase 0 ID, 1 password, 2 idle, 3 showing, 4 answering
    int m_ph, m_score, m_q, m_left;
    int m_hist[$];
    int m_ent[$];
    bit m_logged, m_idok, m_cor, m_ul_prev, m_ld_prev;

    task automatic model_reset();
        m_ph = 0; m_score = 0; m_q = 0; m_left = 0;
        m_hist.delete(); m_ent.delete();
        m_logged = 0; m_idok = 0; m_cor = 0; m_ul_prev = 0; m_ld_prev = 0;
    endtask

    // Standard Morse: 1..5 start with d dots, 6..9 start with d-5 dashes, 0 is all dashes
    function automatic bit is_dash(input int d, input int i);
        if (d == 0) return 1'b1;
        if (d <= 5) return (i >= d);
        return (i < d - 5);
    endfunction

    task automatic model_step(input bit ul, input bit ld, input bit lo, input int d, input int diff);
        bit ulp, ldp;
        int v, need;
        ulp = ul && !m_ul_prev;
        ldp = ld && !m_ld_prev;
        m_ul_prev = ul;
        m_ld_prev = ld;
        if (lo && m_ph != 0) begin
            m_ph = 0; m_hist.delete(); m_ent.delete();
            m_score = 0; m_q = 0; m_logged = 0; m_idok = 0; m_cor = 0;
        end else if (ldp && (m_ph == 3 || m_ph == 4)) begin
            m_cor = (d == m_q);
            if (m_cor) m_score = (m_score + 1) % 10;
            m_q = (m_q + 7) % 10;
            m_ph = 2;
        end else if (ulp && m_ph <= 1) begin
            m_ent.push_back(d);
            m_hist.push_back(d);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            need = (m_ph == 0) ? 4 : 6;
            if (m_ent.size() == need) begin
                v = 0;
                foreach (m_ent[k]) v = v * 16 + m_ent[k];
                m_ent.delete();
                if (m_ph == 0) begin
                    if (v == 'h5973) begin m_idok = 1; m_ph = 1; end
                end else if (v == 'hA04A54) begin
                    m_logged = 1; m_score = 0; m_q = 0; m_ph = 2;
                end else begin
                    m_idok = 0; m_ph = 0;
                end
            end
        end else if (ulp && m_ph == 2) begin
            m_ph = 3;
            m_cor = 0;
            m_left = (diff == 0) ? -1 : (16 >> (diff - 1));
        end else if (m_ph == 3 && m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ph = 4;
        end
    endtask

    function automatic logic [44:0] exp_vec();
        logic [6:0] d [5];
        logic [6:0] ones;
        for (int i = 0; i < 5; i++) d[i] = 7'h7F;
        ones = 7'h7F;
        if (m_ph <= 1) begin
            for (int i = 0; i < 4; i++)
                if (m_hist.size() > i) d[i] = hex_tab[m_hist[m_hist.size() - 1 - i]];
            ones = d[0];
        end else begin
            ones = hex_tab[m_score];
            if (m_ph == 3)
                for (int i = 0; i < 5; i++) d[4 - i] = is_dash(m_q, i) ? 7'h3F : 7'h77;
        end
        return {m_logged, m_idok, m_cor, d[4], d[3], d[2], d[1], d[0], ones};
    endfunction

    function automatic logic [44:0] act_vec();
        return {LoggedInLED, correctID, correct, display4, display3, display2,
                display1, display0, ones_output};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge
    task automatic tick(input bit ul, input bit ld, input bit lo, input logic [3:0] d, input logic [1:0] diff);
        UserLoad = ul; load = ld; logout = lo; UserDigit = d; difficulty = diff;
        @(posedge clk);
        model_step(ul, ld, lo, int'(d), int'(diff));
        @(negedge clk);
        chk("model", 64'(act_vec()), 64'(exp_vec()));
    endtask

    task automatic press(input logic [3:0] d);
        tick(1, 0, 0, d, 2'd0);
        tick(0, 0, 0, d, 2'd0);
    endtask

    task automatic do_reset();
        UserLoad = 0; load = 0; logout = 0;
        rst = 1'b1;
        #1;
        chk("reset_outputs", 64'(act_vec()), {19'd0, 3'b000, {6{7'h7F}}});
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_login();
        logic [3:0] seq [10];
        seq = '{4'h5, 4'h9, 4'h7, 4'h3, 4'hA, 4'h0, 4'h4, 4'hA, 4'h5, 4'h4};
        for (int i = 0; i < 10; i++) press(seq[i]);
    endtask

    typedef struct {
        logic [3:0] digit;
        logic       exp_id;
        logic       exp_led;
        logic [6:0] exp_d0;
        logic [6:0] exp_d3;
        logic [6:0] exp_ones;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'h5, 1'b0, 1'b0, 7'h12, 7'h7F, 7'h12};
        tbl[1] = '{4'h9, 1'b0, 1'b0, 7'h10, 7'h7F, 7'h10};
        tbl[2] = '{4'h7, 1'b0, 1'b0, 7'h78, 7'h7F, 7'h78};
        tbl[3] = '{4'h3, 1'b1, 1'b0, 7'h30, 7'h12, 7'h30};
        tbl[4] = '{4'hA, 1'b1, 1'b0, 7'h08, 7'h10, 7'h08};
        tbl[5] = '{4'h0, 1'b1, 1'b0, 7'h40, 7'h78, 7'h40};
        tbl[6] = '{4'h4, 1'b1, 1'b0, 7'h19, 7'h30, 7'h19};
        tbl[7] = '{4'hA, 1'b1, 1'b0, 7'h08, 7'h08, 7'h08};
        tbl[8] = '{4'h5, 1'b1, 1'b0, 7'h12, 7'h40, 7'h12};
        tbl[9] = '{4'h4, 1'b1, 1'b1, 7'h7F, 7'h7F, 7'h40};

        @(negedge clk);
        do_reset();

        // Login through the vector table
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, tbl[i].digit, 2'd0);
            chk("tbl_correctID", 64'(correctID), 64'(tbl[i].exp_id));
            chk("tbl_led", 64'(LoggedInLED), 64'(tbl[i].exp_led));
            chk("tbl_display0", 64'(display0), 64'(tbl[i].exp_d0));
            chk("tbl_display3", 64'(display3), 64'(tbl[i].exp_d3));
            chk("tbl_ones", 64'(ones_output), 64'(tbl[i].exp_ones));
            chk("tbl_display4", 64'(display4), 64'h7F);
            tick(0, 0, 0, tbl[i].digit, 2'd0);
        end

        // Round 1: digit 0 at difficulty 01, visible for exactly 16 cycles
        tick(1, 0, 0, 4'd0, 2'b01);
        chk("show0_first", 64'({display4, display3, display2, display1, display0}), 64'({5{7'h3F}}));
        for (int k = 1; k < 16; k++) begin
            tick(0, 0, 0, 4'd0, 2'b01);
            chk("show0_hold", 64'({display4, display3, display2, display1, display0}), 64'({5{7'h3F}}));
        end
        tick(0, 0, 0, 4'd0, 2'b01);
        chk("show0_expired", 64'({display4, display3, display2, display1, display0}), 64'({5{7'h7F}}));
        tick(0, 1, 0, 4'd0, 2'b01);
        chk("ans0_correct", 64'(correct), 64'd1);
        chk("ans0_score", 64'(ones_output), 64'h79);
        tick(0, 0, 0, 4'd0, 2'b01);

        // Round 2: digit 7, unlimited visibility, wrong answer
        tick(1, 0, 0, 4'd3, 2'b00);
        chk("show7", 64'({display4, display3, display2, display1, display0}),
            64'({7'h3F, 7'h3F, 7'h77, 7'h77, 7'h77}));
        chk("round_clears_correct", 64'(correct), 64'd0);
        tick(0, 0, 0, 4'd3, 2'b00);
        tick(0, 1, 0, 4'd3, 2'b00);
        chk("ans7_correct", 64'(correct), 64'd0);
        chk("ans7_score", 64'(ones_output), 64'h79);
        tick(0, 0, 0, 4'd3, 2'b00);

        // Logout during the pattern
        tick(1, 0, 0, 4'd0, 2'b00);
        tick(0, 0, 1, 4'd0, 2'b00);
        chk("logout_flags", 64'({LoggedInLED, correctID, correct}), 64'd0);
        chk("logout_displays", 64'({display4, display3, display2, display1, display0, ones_output}),
            64'({6{7'h7F}}));
        tick(0, 0, 0, 4'd0, 2'b00);

        // Wrong ID, then right ID and wrong password
        press(4'h5); press(4'h9); press(4'h7);
        tick(1, 0, 0, 4'h2, 2'd0);
        chk("bad_id", 64'(correctID), 64'd0);
        chk("bad_id_d0", 64'(display0), 64'h24);
        tick(0, 0, 0, 4'h2, 2'd0);
        press(4'h5); press(4'h9); press(4'h7); press(4'h3);
        chk("good_id", 64'(correctID), 64'd1);
        for (int i = 1; i <= 5; i++) press(4'(i));
        tick(1, 0, 0, 4'h6, 2'd0);
        chk("bad_pwd", 64'({correctID, LoggedInLED}), 64'd0);
        tick(0, 0, 0, 4'h6, 2'd0);

        // Reset in the middle of a password
        press(4'h5); press(4'h9); press(4'h7); press(4'h3); press(4'hA); press(4'h0);
        @(negedge clk);
        do_reset();

        // Randomised sessions against the model
        for (int r = 0; r < 3; r++) begin
            do_login();
            for (int n = 0; n < 400; n++) begin
                tick(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 90) == 0,
                     4'($urandom % 10), 2'($urandom % 4));
            end
            @(negedge clk);
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
